// File: rtl/branch_merger_pkg.sv
// ---------------------------------------------------------------------------
// branch_merger_pkg
//   Shared core configuration for the branch merger and the branch router:
//   commit-id width, number of instruction branches and fixed result-field
//   widths, plus the grant-source type used by the merger.
//
//   Core macros (overridable on the command line):
//     COMMIT_ID_WIDTH   width of commit_id fields (default 4)
//     N_INSTR_BRANCHES  number of execution branches (default 4)
// ---------------------------------------------------------------------------
`ifndef COMMIT_ID_WIDTH
`define COMMIT_ID_WIDTH 4
`endif

`ifndef N_INSTR_BRANCHES
`define N_INSTR_BRANCHES 4
`endif

package branch_merger_pkg;

    localparam int COMMIT_ID_WIDTH  = `COMMIT_ID_WIDTH;
    localparam int N_INSTR_BRANCHES = `N_INSTR_BRANCHES;
    localparam int DEST_WIDTH       = 4;
    localparam int RES_ADDR_WIDTH   = 8;

    // Which path produced this cycle's grant.
    typedef enum logic [1:0] {
        SRC_NONE   = 2'd0,
        SRC_COMMIT = 2'd1,
        SRC_FREE   = 2'd2
    } grant_src_t;

endpackage

// File: rtl/branch_merger_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Round-robin arbiter with its own pointer register. The search starts at
//   the pointer; on 'advance' the pointer moves to one past the granted index.
//
//   Ports:
//     clk        in   clock, posedge
//     reset      in   asynchronous, active-high
//     req        in   [n]   request vector
//     advance    in   1     the current grant was consumed
//     grant      out  [n]   one-hot grant (combinational)
//     grant_idx  out  [IW]  index of the granted requester
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int n = 4,
    localparam int IW = (n > 1) ? $clog2(n) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [n-1:0]  req,
    input  logic          advance,
    output logic [n-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] pointer;

    // NOTE: every output of a combinational block gets a default first, so
    // no path through the loop can leave a value unassigned and infer a latch.
    always_comb begin
        int  idx;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < n; k++) begin
            idx = (int'(pointer) + k) % n;
            if (!found && req[idx]) begin
                found          = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = IW'(idx);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pointer <= '0;
        end else if (advance) begin
            pointer <= (grant_idx == IW'(n - 1)) ? '0 : grant_idx + IW'(1);
        end
    end

endmodule

// File: rtl/branch_merger.sv
// ---------------------------------------------------------------------------
// branch_merger
//   Merges the result streams of the execution branches into one stream for
//   commit/writeback. Ordered entries (commit_flag=1) leave strictly in
//   commit_id order; free entries (commit_flag=0) are merged round-robin.
//   One registered output stage, valid/ready on every input and the output.
//
//   Ports:
//     clk, reset           clock (posedge), asynchronous active-high reset
//     enable               0 freezes all state and drops every in_ready
//     in_valid/in_ready    per-branch handshake (in_ready is combinational)
//     *_in                 per-branch fields, branch i in slice i
//     out_valid/out_ready  output handshake
//     *_out                registered copy of the last granted entry
//     expected_id          next commit_id allowed out
//     order_error          sticky protocol-error flag
//
//   Configuration:
//     BRANCH_MERGER_ORDER_CHECK_EN  when defined, builds the order checker
//     (duplicate ordered ids in one cycle, committed id != expected_id).
//     Otherwise order_error is tied 0.
// ---------------------------------------------------------------------------
module branch_merger
    import branch_merger_pkg::*;
#(
    parameter int data_width = 16,
    parameter int n_blocks   = 256,
    parameter int n_branches = N_INSTR_BRANCHES,
    localparam int BW  = $clog2(n_blocks),
    localparam int CIW = COMMIT_ID_WIDTH,
    localparam int DW  = DEST_WIDTH,
    localparam int AW  = RES_ADDR_WIDTH,
    localparam int IW  = (n_branches > 1) ? $clog2(n_branches) : 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               enable,
    input  logic [n_branches-1:0]              in_valid,
    output logic [n_branches-1:0]              in_ready,
    input  logic [n_branches*BW-1:0]           block_in,
    input  logic [n_branches*DW-1:0]           dest_in,
    input  logic [n_branches*data_width-1:0]   result_in,
    input  logic [n_branches*2*data_width-1:0] accumulator_in,
    input  logic [n_branches-1:0]              writes_external_in,
    input  logic [n_branches*AW-1:0]           res_addr_in,
    input  logic [n_branches*CIW-1:0]          commit_id_in,
    input  logic [n_branches-1:0]              commit_flag_in,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [BW-1:0]                      block_out,
    output logic [DW-1:0]                      dest_out,
    output logic [data_width-1:0]              result_out,
    output logic [2*data_width-1:0]            accumulator_out,
    output logic                               writes_external_out,
    output logic [AW-1:0]                      res_addr_out,
    output logic [CIW-1:0]                     commit_id_out,
    output logic                               commit_flag_out,
    output logic [CIW-1:0]                     expected_id,
    output logic                               order_error
);

    logic [n_branches-1:0] commit_cand;
    logic [n_branches-1:0] free_cand;
    logic [n_branches-1:0] commit_grant;
    logic [IW-1:0]         commit_idx;
    logic [n_branches-1:0] rr_grant;
    logic [IW-1:0]         rr_idx;
    logic [n_branches-1:0] grant;
    logic [IW-1:0]         sel_idx;
    grant_src_t            src;
    logic                  can_load;
    logic                  xfer;
    logic [CIW-1:0]        sel_id;

    // Candidate classification.
    always_comb begin
        for (int i = 0; i < n_branches; i++) begin
            commit_cand[i] = in_valid[i] & commit_flag_in[i]
                           & (commit_id_in[i*CIW +: CIW] == expected_id);
            free_cand[i]   = in_valid[i] & ~commit_flag_in[i];
        end
    end

    // Lowest-index commit candidate wins. Only one branch can legally hold
    // expected_id, so the priority only matters under protocol errors.
    always_comb begin
        logic found;
        found        = 1'b0;
        commit_grant = '0;
        commit_idx   = '0;
        for (int i = 0; i < n_branches; i++) begin
            if (!found && commit_cand[i]) begin
                found           = 1'b1;
                commit_grant[i] = 1'b1;
                commit_idx      = IW'(i);
            end
        end
    end

    rr_arbiter #(.n(n_branches)) u_rr_arbiter (
        .clk       (clk),
        .reset     (reset),
        .req       (free_cand),
        .advance   (xfer && (src == SRC_FREE)),
        .grant     (rr_grant),
        .grant_idx (rr_idx)
    );

    // Ordered traffic has absolute priority over free traffic.
    always_comb begin
        if (|commit_grant) begin
            src     = SRC_COMMIT;
            grant   = commit_grant;
            sel_idx = commit_idx;
        end else if (|rr_grant) begin
            src     = SRC_FREE;
            grant   = rr_grant;
            sel_idx = rr_idx;
        end else begin
            src     = SRC_NONE;
            grant   = '0;
            sel_idx = '0;
        end
    end

    assign can_load = enable & (~out_valid | out_ready);
    assign in_ready = can_load ? grant : '0;
    assign xfer     = can_load & (|grant);
    assign sel_id   = commit_id_in[sel_idx*CIW +: CIW];

    // Output stage and ordering counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid           <= 1'b0;
            block_out           <= '0;
            dest_out            <= '0;
            result_out          <= '0;
            accumulator_out     <= '0;
            writes_external_out <= 1'b0;
            res_addr_out        <= '0;
            commit_id_out       <= '0;
            commit_flag_out     <= 1'b0;
            expected_id         <= '0;
        end else if (xfer) begin
            out_valid           <= 1'b1;
            block_out           <= block_in[sel_idx*BW +: BW];
            dest_out            <= dest_in[sel_idx*DW +: DW];
            result_out          <= result_in[sel_idx*data_width +: data_width];
            accumulator_out     <= accumulator_in[sel_idx*2*data_width +: 2*data_width];
            writes_external_out <= writes_external_in[sel_idx];
            res_addr_out        <= res_addr_in[sel_idx*AW +: AW];
            commit_id_out       <= sel_id;
            commit_flag_out     <= commit_flag_in[sel_idx];
            // Natural CIW-bit wrap: max -> 0.
            if (src == SRC_COMMIT) begin
                expected_id <= expected_id + CIW'(1);
            end
        end else if (enable && out_valid && out_ready) begin
            // Drained with nothing new: drop valid, data holds.
            out_valid <= 1'b0;
        end
    end

`ifdef BRANCH_MERGER_ORDER_CHECK_EN
    logic dup_id;
    logic id_mismatch;

    // Two ordered entries carrying the same id in one cycle.
    always_comb begin
        dup_id = 1'b0;
        for (int i = 0; i < n_branches; i++) begin
            for (int j = i + 1; j < n_branches; j++) begin
                if (in_valid[i] && commit_flag_in[i] && in_valid[j] && commit_flag_in[j]
                    && (commit_id_in[i*CIW +: CIW] == commit_id_in[j*CIW +: CIW])) begin
                    dup_id = 1'b1;
                end
            end
        end
    end

    // Sanity: a committed entry must carry expected_id.
    assign id_mismatch = xfer && (src == SRC_COMMIT) && (sel_id != expected_id);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            order_error <= 1'b0;
        end else if (enable && (dup_id || id_mismatch)) begin
            order_error <= 1'b1;
        end
    end
`else
    assign order_error = 1'b0;
`endif

endmodule
